// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: opcodes, 2-bit predictor counter states,
// and a constant log2 helper for table index widths.
package rv_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v != 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle of the branch predictor; the pipeline
// drives it through master, the predictor consumes it through slave.
interface branch_predictor_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = 32
);

  logic [XLEN-1:0] PCF;
  logic            PredTakenF;
  logic            ValidE;
  logic [6:0]      OpE;
  logic [XLEN-1:0] PCE;
  logic            TakenE;
  logic            PredTakenE;
  logic            MispredictE;
  logic            CntClr;
  logic [CNTW-1:0] BranchCnt;
  logic [CNTW-1:0] MissCnt;

  modport master (
    output PCF, ValidE, OpE, PCE, TakenE, PredTakenE, CntClr,
    input  PredTakenF, MispredictE, BranchCnt, MissCnt
  );

  modport slave (
    input  PCF, ValidE, OpE, PCE, TakenE, PredTakenE, CntClr,
    output PredTakenF, MispredictE, BranchCnt, MissCnt
  );

endinterface

// File: rtl/sat_counter2.sv
// Single 2-bit saturating up/down counter with enable and parameterised
// reset value; one instance per predictor table entry.
module sat_counter2
  import rv_pkg::*;
#(
  parameter logic [1:0] INIT = 2'b01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       up_i,
  output logic [1:0] cnt_o
);

  ctr_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      if (up_i) begin
        if (state_q != ST) state_d = ctr_e'(state_q + 2'd1);
      end else begin
        if (state_q != SNT) state_d = ctr_e'(state_q - 2'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ctr_e'(INIT);
    else        state_q <= state_d;
  end

  assign cnt_o = state_q;

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor: untagged table of 2-bit counters read at
// fetch, trained at execute, with mispredict flag and saturating perf counters.
module branch_predictor
  import rv_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned XLEN    = 32,
  parameter logic [1:0]  INIT    = 2'b01,
  parameter int unsigned CNTW    = 32
) (
  input logic               clk,
  input logic               reset_n,
  branch_predictor_if.slave bp
);

  localparam int unsigned IDXW = clog2(ENTRIES);

  logic [IDXW-1:0] fidx;
  logic [IDXW-1:0] uidx;
  logic            upd;
  logic            mispredict;
  logic [1:0]      cnt [ENTRIES];

  logic [CNTW-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNTW-1:0] miss_cnt_q, miss_cnt_d;

  assign fidx = bp.PCF[IDXW+1:2];
  assign uidx = bp.PCE[IDXW+1:2];

  // Gating with upd keeps TakenE/PredTakenE from reaching any state when idle.
  assign upd        = bp.ValidE && (bp.OpE == OP_BRANCH);
  assign mispredict = upd && (bp.TakenE != bp.PredTakenE);

  for (genvar g = 0; g < ENTRIES; g++) begin : g_tbl
    sat_counter2 #(.INIT(INIT)) u_ctr (
      .clk  (clk),
      .rst_n(reset_n),
      .en_i (upd && (uidx == IDXW'(g))),
      .up_i (bp.TakenE),
      .cnt_o(cnt[g])
    );
  end

  // Read straight from the registered entries: a same-cycle update is not bypassed.
  assign bp.PredTakenF  = cnt[fidx][1];
  assign bp.MispredictE = mispredict;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (bp.CntClr) begin
      branch_cnt_d = '0;
      miss_cnt_d   = '0;
    end else begin
      if (upd && !(&branch_cnt_q))      branch_cnt_d = branch_cnt_q + CNTW'(1);
      if (mispredict && !(&miss_cnt_q)) miss_cnt_d   = miss_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign bp.BranchCnt = branch_cnt_q;
  assign bp.MissCnt   = miss_cnt_q;

  logic unused_pc;
  assign unused_pc = ^{bp.PCF[XLEN-1:IDXW+2], bp.PCF[1:0],
                       bp.PCE[XLEN-1:IDXW+2], bp.PCE[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: vector tables fed through a
// scoreboard queue plus hand sequences for async reset and counter saturation.
module tb_branch_predictor;
  import rv_pkg::*;

  localparam int unsigned XLEN_TB = 32;
  localparam int unsigned CNTW_TB = 4;

  logic clk;
  logic reset_n;

  branch_predictor_if #(.XLEN(XLEN_TB), .CNTW(CNTW_TB)) bp_if ();

  branch_predictor #(
    .ENTRIES(64),
    .XLEN   (XLEN_TB),
    .INIT   (2'b01),
    .CNTW   (CNTW_TB)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bp     (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [6:0]  op;
    logic [31:0] pce;
    logic        tk;
    logic        pe;
    logic [31:0] pcf;
    logic        clr;
    logic        epred;
    logic        emis;
    int          ebc;
    int          emc;
  } vec_t;

  vec_t sb[$];
  vec_t grp_a[$];
  vec_t grp_b[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t mk(input logic valid, input logic [6:0] op,
                              input logic [31:0] pce, input logic tk, input logic pe,
                              input logic [31:0] pcf, input logic clr,
                              input logic epred, input logic emis,
                              input int ebc, input int emc);
    vec_t v;
    v.valid = valid; v.op = op; v.pce = pce; v.tk = tk; v.pe = pe;
    v.pcf = pcf; v.clr = clr; v.epred = epred; v.emis = emis;
    v.ebc = ebc; v.emc = emc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive_idle(input logic [31:0] pcf);
    bp_if.PCF = pcf; bp_if.ValidE = 1'b0; bp_if.OpE = 7'd0; bp_if.PCE = '0;
    bp_if.TakenE = 1'b0; bp_if.PredTakenE = 1'b0; bp_if.CntClr = 1'b0;
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    bp_if.PCF = v.pcf; bp_if.ValidE = v.valid; bp_if.OpE = v.op; bp_if.PCE = v.pce;
    bp_if.TakenE = v.tk; bp_if.PredTakenE = v.pe; bp_if.CntClr = v.clr;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, ".pred"}, int'(bp_if.PredTakenF), int'(e.epred));
    chk({tag, ".mis"},  int'(bp_if.MispredictE), int'(e.emis));
    @(posedge clk); #1;
    chk({tag, ".bcnt"}, int'(bp_if.BranchCnt), e.ebc);
    chk({tag, ".mcnt"}, int'(bp_if.MissCnt), e.emc);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive_idle(32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    drive_idle(32'h0);

    // Index = PC[7:2]; 0x000, 0x100, 0x200 and 0x300 all alias to entry 0.
    grp_a.push_back(mk(0, 7'd0,      32'h000, 0, 0, 32'h100, 0, 0, 0, 0, 0));
    grp_a.push_back(mk(1, OP_BRANCH, 32'h100, 1, 0, 32'h100, 0, 0, 1, 1, 1));
    grp_a.push_back(mk(1, OP_BRANCH, 32'h100, 1, 1, 32'h100, 0, 1, 0, 2, 1));
    grp_a.push_back(mk(1, OP_BRANCH, 32'h100, 1, 1, 32'h100, 0, 1, 0, 3, 1));
    grp_a.push_back(mk(1, OP_BRANCH, 32'h100, 0, 1, 32'h100, 0, 1, 1, 4, 2));
    grp_a.push_back(mk(1, OP_BRANCH, 32'h100, 0, 1, 32'h100, 0, 1, 1, 5, 3));
    grp_a.push_back(mk(1, OP_BRANCH, 32'h100, 0, 0, 32'h100, 0, 0, 0, 6, 3));
    grp_a.push_back(mk(1, OP_BRANCH, 32'h100, 0, 0, 32'h100, 0, 0, 0, 7, 3));
    grp_a.push_back(mk(1, OP_BRANCH, 32'h100, 0, 0, 32'h100, 0, 0, 0, 8, 3));
    grp_a.push_back(mk(1, OP_BRANCH, 32'h100, 1, 0, 32'h100, 0, 0, 1, 9, 4));
    grp_a.push_back(mk(1, OP_BRANCH, 32'h100, 1, 0, 32'h100, 0, 0, 1, 10, 5));
    grp_a.push_back(mk(0, 7'd0,      32'h000, 0, 0, 32'h100, 0, 1, 0, 10, 5));
    grp_a.push_back(mk(1, OP_JAL,    32'h100, 1, 0, 32'h100, 0, 1, 0, 10, 5));
    grp_a.push_back(mk(0, OP_BRANCH, 32'h100, 1, 0, 32'h100, 0, 1, 0, 10, 5));
    grp_a.push_back(mk(1, OP_JALR,   32'h100, 0, 1, 32'h100, 0, 1, 0, 10, 5));
    grp_a.push_back(mk(0, 7'd0,      32'h000, 0, 0, 32'h100, 0, 1, 0, 10, 5));
    grp_a.push_back(mk(1, OP_BRANCH, 32'h100, 0, 1, 32'h100, 0, 1, 1, 11, 6));
    grp_a.push_back(mk(0, 7'd0,      32'h000, 0, 0, 32'h100, 0, 0, 0, 11, 6));
    grp_a.push_back(mk(1, OP_BRANCH, 32'h000, 1, 0, 32'h100, 0, 0, 1, 12, 7));
    grp_a.push_back(mk(0, 7'd0,      32'h000, 0, 0, 32'h100, 0, 1, 0, 12, 7));
    grp_a.push_back(mk(0, 7'd0,      32'h000, 0, 0, 32'h104, 0, 0, 0, 12, 7));
    grp_a.push_back(mk(1, OP_BRANCH, 32'h104, 1, 0, 32'h104, 1, 0, 1, 0, 0));
    grp_a.push_back(mk(0, 7'd0,      32'h000, 0, 0, 32'h104, 0, 1, 0, 0, 0));
    grp_a.push_back(mk(1, OP_BRANCH, 32'h300, 0, 1, 32'h300, 0, 1, 1, 1, 1));
    grp_a.push_back(mk(1, OP_BRANCH, 32'h300, 1, 0, 32'h300, 0, 0, 1, 2, 2));
    grp_a.push_back(mk(0, 7'd0,      32'h000, 0, 0, 32'h300, 0, 1, 0, 2, 2));

    // Back-to-back branches: the first two were predicted before entry trained.
    grp_b.push_back(mk(0, 7'd0,      32'h000, 0, 0, 32'h200, 0, 0, 0, 0, 0));
    grp_b.push_back(mk(1, OP_BRANCH, 32'h200, 1, 0, 32'h200, 0, 0, 1, 1, 1));
    grp_b.push_back(mk(1, OP_BRANCH, 32'h200, 1, 0, 32'h200, 0, 1, 1, 2, 2));
    grp_b.push_back(mk(1, OP_BRANCH, 32'h200, 1, 1, 32'h200, 0, 1, 0, 3, 2));
    grp_b.push_back(mk(1, OP_BRANCH, 32'h200, 1, 1, 32'h200, 0, 1, 0, 4, 2));
    grp_b.push_back(mk(1, OP_BRANCH, 32'h200, 1, 1, 32'h200, 1, 1, 0, 0, 0));
    grp_b.push_back(mk(0, 7'd0,      32'h000, 0, 0, 32'h200, 0, 1, 0, 0, 0));

    do_reset();
    foreach (grp_a[i]) apply($sformatf("A%0d", i), grp_a[i]);

    do_reset();
    foreach (grp_b[i]) apply($sformatf("B%0d", i), grp_b[i]);

    // Entry 0 is at 11 here; 20 not-taken mispredicts walk it down and saturate both counters.
    for (int i = 0; i < 20; i++) begin
      int sat;
      sat = (i + 1 > 15) ? 15 : i + 1;
      apply($sformatf("S%0d", i),
            mk(1, OP_BRANCH, 32'h200, 0, 1, 32'h200, 0, (i < 2) ? 1'b1 : 1'b0, 1, sat, sat));
    end

    // Train 0x40 to 11, then assert reset asynchronously over an update.
    do_reset();
    apply("C0", mk(1, OP_BRANCH, 32'h040, 1, 0, 32'h040, 0, 0, 1, 1, 1));
    apply("C1", mk(1, OP_BRANCH, 32'h040, 1, 1, 32'h040, 0, 1, 0, 2, 1));
    apply("C2", mk(1, OP_BRANCH, 32'h040, 1, 1, 32'h040, 0, 1, 0, 3, 1));
    apply("C3", mk(0, 7'd0,      32'h000, 0, 0, 32'h040, 0, 1, 0, 3, 1));
    bp_if.PCF = 32'h040; bp_if.ValidE = 1'b1; bp_if.OpE = OP_BRANCH;
    bp_if.PCE = 32'h040; bp_if.TakenE = 1'b1; bp_if.PredTakenE = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async.pred", int'(bp_if.PredTakenF), 0);
    chk("rst_async.bcnt", int'(bp_if.BranchCnt), 0);
    chk("rst_async.mcnt", int'(bp_if.MissCnt), 0);
    chk("rst_async.mis",  int'(bp_if.MispredictE), 1);
    @(posedge clk); #1;
    chk("rst_hold.pred", int'(bp_if.PredTakenF), 0);
    chk("rst_hold.bcnt", int'(bp_if.BranchCnt), 0);
    @(negedge clk);
    drive_idle(32'h040);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rel.pred", int'(bp_if.PredTakenF), 0);
    chk("rst_rel.bcnt", int'(bp_if.BranchCnt), 0);
    chk("rst_rel.mcnt", int'(bp_if.MissCnt), 0);
    apply("C4", mk(1, OP_BRANCH, 32'h040, 1, 0, 32'h040, 0, 0, 1, 1, 1));
    apply("C5", mk(0, 7'd0,      32'h000, 0, 0, 32'h040, 0, 1, 0, 1, 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
